// File: rtl/mul_wb_unit.sv
// Iterative unsigned W x W shift-add multiplier that retires its 2W-bit product
// as two register-file writes: low half to dst, then high half to r0.
module mul_wb_unit #(
    parameter int W  = 8,
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  opA,
    input  logic [W-1:0]  opB,
    input  logic [pw-1:0] dst,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [pw-1:0] wr_addr,
    output logic [W-1:0]  dat_out
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, WR_LO, WR_HI} state_t;

    state_t           state;
    logic [W-1:0]     mcand;
    logic [2*W-1:0]   acc;
    logic [pw-1:0]    dst_q;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     addend;
    logic [W:0]       sum;
    logic [2*W-1:0]   acc_next;

    // The multiplier lives in the low half of acc: its LSB selects the add, and
    // each shift retires one multiplier bit while a product bit shifts in on top.
    always_comb begin
        addend   = acc[0] ? mcand : '0;
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, addend};
        acc_next = {sum, acc[W-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            dst_q   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            dat_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= opA;
                        acc   <= {{W{1'b0}}, opB};
                        dst_q <= dst;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        wr_en   <= 1'b1;
                        wr_addr <= dst_q;
                        dat_out <= acc_next[W-1:0];
                        state   <= WR_LO;
                    end
                end
                WR_LO: begin
                    wr_addr <= '0;
                    dat_out <= acc[2*W-1:W];
                    done    <= 1'b1;
                    state   <= WR_HI;
                end
                WR_HI: begin
                    wr_en   <= 1'b0;
                    wr_addr <= '0;
                    dat_out <= '0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_wb_unit.md
Name: mul_wb_unit

Overview:
- Iterative unsigned 8x8 multiplier for the custom CPU datapath.
- Consumes the two register-file read operands (datA/datB); feeds the register-file write port (dat_in/wr_addr/wr_en).
- Produces a 16-bit product in 8 shift-add cycles.
- Retires the product as two register-file writes: low byte to the destination register, high byte to r0.

Parameters:
- W, 8, operand width in bits; product is 2*W bits.
- pw, 3, register address width; must match the register file's pw.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- opA  input  W  multiplicand (register-file datA_out).
- opB  input  W  multiplier (register-file datB_out).
- dst  input  pw  destination register for the product low byte.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse during the final write cycle.
- wr_en  output  1  register-file write enable.
- wr_addr  output  pw  register-file write address.
- dat_out  output  W  register-file write data (drives dat_in).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, wr_en=0, wr_addr=0, dat_out=0; internal accumulator, operand copies, dst copy and counter all cleared.
- Output style: Moore. All outputs are decoded from registered state and registered data only; nothing is combinational from inputs.
- States: IDLE, CALC, WR_LO, WR_HI.
- IDLE:
  - On an edge with start=1: latch opA, opB and dst; clear the 2W-bit accumulator and the counter; go to CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge, 8 iterations (counter 0..W-1):
  - If multiplier LSB=1, add the multiplicand into the accumulator upper half with carry-out kept (W+1-bit add).
  - Shift {carry, accumulator} right by 1. Shift the multiplier right by 1.
  - When counter=W-1, go to WR_LO.
  - Result is the exact unsigned product opA*opB in 2W bits; no overflow or truncation.
- WR_LO: wr_en=1, wr_addr=latched dst, dat_out=product[W-1:0]. Next state WR_HI.
- WR_HI: wr_en=1, wr_addr=0, dat_out=product[2W-1:W], done=1. Next state IDLE.
- Outside WR_LO/WR_HI: wr_en=0, done=0; wr_addr and dat_out are held at 0.
- Latency, with the start-sampling edge as E0:
  - busy rises after E0.
  - wr_en is high in the cycles after E8 and E9; the register file captures on E9 (low byte) and E10 (high byte).
  - busy falls after E10.
  - Earliest next start is sampled at E11; the repeat interval is 11 cycles.
- start while busy (including during WR_HI): ignored; no queuing.
- Operand changes after E0: no effect; only the latched copies are used.
- dst=0: low byte goes to r0 on E9 and is overwritten by the high byte on E10, so r0 ends holding the high byte. This is defined behaviour, not an error.
- Zero operands: still 8 CALC cycles; both writes are 0x00.
- Reset mid-operation: immediate return to reset values. Any in-flight write is abandoned (wr_en drops asynchronously). Neither pending write occurs.

Test Plan:
- opA=13, opB=11, dst=5, start pulse at E0:
  - wr_en=1 with wr_addr=5, dat_out=0x8F after E8.
  - wr_addr=0, dat_out=0x00, done=1 after E9.
  - busy low after E10.
- opA=0xFF, opB=0xFF, dst=2: writes 0x01 to r2, then 0xFE to r0; register file ends with r2=0x01, r0=0xFE.
- opA=16, opB=16, dst=0: writes 0x00 then 0x01 to r0; final r0=0x01; done pulses exactly once.
- opA=7, opB=3, dst=1 at E0, then start=1 with opA=9 held every cycle:
  - First result 0x15 to r1 is unaffected by the new operands.
  - Second operation is accepted at E11, not earlier.
- opA=0, opB=0xAB, dst=4: busy for 10 cycles; r4=0x00 and r0=0x00 written.
- reset asserted mid-cycle after E4 of an operation:
  - All outputs are 0 immediately; no wr_en pulse occurs.
  - After release, a new start (opA=2, opB=3, dst=6) yields r6=0x06 with normal latency.
